// File: rtl/cpu_defs.sv
// Shared definitions for the next-PC path: npc_op encodings, sequencer
// states and the default IFU reset vector.
package cpu_defs;

    localparam logic [1:0] NPC_SEQ    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JREG   = 2'd3;

    typedef enum logic {
        S_SEQ  = 1'b0,
        S_SLOT = 1'b1
    } npc_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/npc_target_calc.sv
// Combinational target arithmetic: fall-through, branch, jump and register
// targets, plus the redirect decision for the current npc_op.
module npc_target_calc
    import cpu_defs::*;
(
    input  logic [31:0] PC,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] ra_val,
    output logic [31:0] pc4,
    output logic [31:0] pc8,
    output logic [31:0] tgt,
    output logic        redirect
);

    logic [31:0] br_off;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;

    assign pc4    = PC + 32'd4;
    assign pc8    = PC + 32'd8;
    assign br_off = {{14{imm16[15]}}, imm16, 2'b00};
    assign br_tgt = pc4 + br_off;
    // Jumps stay within the 256 MB region of the instruction after the jump.
    assign j_tgt  = {pc4[31:28], imm26, 2'b00};

    always_comb begin
        tgt      = pc4;
        redirect = 1'b0;
        case (npc_op)
            NPC_BRANCH: begin
                tgt      = br_tgt;
                redirect = br_taken;
            end
            NPC_JUMP: begin
                tgt      = j_tgt;
                redirect = 1'b1;
            end
            NPC_JREG: begin
                tgt      = ra_val;
                redirect = 1'b1;
            end
            default: begin
                tgt      = pc4;
                redirect = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/npc_sequencer.sv
// Next-PC sequencer driving the IFU: sequential fetch, branches and jumps,
// with optional MIPS delay-slot handling through a pending-target register.
module npc_sequencer
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] ra_val,
    input  logic        stall,
    output logic [31:0] NPC,
    output logic [31:0] link_addr,
    output logic        in_slot
);

    npc_state_t  st;
    npc_state_t  st_next;
    logic [31:0] pend_tgt;
    logic [31:0] pend_next;

    logic [31:0] pc4;
    logic [31:0] pc8;
    logic [31:0] tgt;
    logic        redirect;

    npc_target_calc u_target (
        .PC       (PC),
        .imm16    (imm16),
        .imm26    (imm26),
        .npc_op   (npc_op),
        .br_taken (br_taken),
        .ra_val   (ra_val),
        .pc4      (pc4),
        .pc8      (pc8),
        .tgt      (tgt),
        .redirect (redirect)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= S_SEQ;
            pend_tgt <= 32'd0;
        end else begin
            st       <= st_next;
            pend_tgt <= pend_next;
        end
    end

    // A stalled instruction is not consumed, so neither state nor the
    // pending target may advance; a redirect seen in the slot is dropped.
    always_comb begin
        st_next   = st;
        pend_next = pend_tgt;
        NPC       = pc4;
        link_addr = pc8;
        in_slot   = 1'b0;

        if (reset) begin
            st_next   = S_SEQ;
            NPC       = RESET_PC;
            link_addr = RESET_PC + 32'd8;
            in_slot   = 1'b0;
        end else if (DELAY_SLOT) begin
            in_slot   = (st == S_SLOT);
            link_addr = pc8;
            case (st)
                S_SEQ: begin
                    if (stall) begin
                        NPC = PC;
                    end else if (redirect) begin
                        NPC       = pc4;
                        pend_next = tgt;
                        st_next   = S_SLOT;
                    end else begin
                        NPC = pc4;
                    end
                end
                S_SLOT: begin
                    if (stall) begin
                        NPC = PC;
                    end else begin
                        NPC     = pend_tgt;
                        st_next = S_SEQ;
                    end
                end
                default: begin
                    NPC     = pc4;
                    st_next = S_SEQ;
                end
            endcase
        end else begin
            st_next   = S_SEQ;
            link_addr = pc4;
            in_slot   = 1'b0;
            if (stall) begin
                NPC = PC;
            end else if (redirect) begin
                NPC = tgt;
            end else begin
                NPC = pc4;
            end
        end
    end

endmodule

// File: tb/tb_npc_sequencer.sv
// Self-checking bench: delay-slot and immediate-redirect builds side by side,
// compared against a queue-based model of pending redirects.
module tb_npc_sequencer;

    localparam logic [31:0] RST_VEC = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [1:0]  npc_op;
    logic        br_taken;
    logic [31:0] ra_val;
    logic        stall;

    logic [31:0] npc_ds;
    logic [31:0] link_ds;
    logic        slot_ds;
    logic [31:0] npc_im;
    logic [31:0] link_im;
    logic        slot_im;

    int checks;
    int errors;

    // Redirect targets awaiting their delay slot; non-empty means "in slot".
    logic [31:0] pend_q[$];
    logic [31:0] exp_npc;
    logic [31:0] exp_link;
    logic        exp_slot;
    logic [31:0] exp_npc_im;
    logic [31:0] exp_link_im;
    logic [31:0] cur_tgt;
    logic        cur_redirect;

    npc_sequencer #(.RESET_PC(RST_VEC), .DELAY_SLOT(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .PC        (PC),
        .imm16     (imm16),
        .imm26     (imm26),
        .npc_op    (npc_op),
        .br_taken  (br_taken),
        .ra_val    (ra_val),
        .stall     (stall),
        .NPC       (npc_ds),
        .link_addr (link_ds),
        .in_slot   (slot_ds)
    );

    npc_sequencer #(.RESET_PC(RST_VEC), .DELAY_SLOT(1'b0)) dut_im (
        .clk       (clk),
        .reset     (reset),
        .PC        (PC),
        .imm16     (imm16),
        .imm26     (imm26),
        .npc_op    (npc_op),
        .br_taken  (br_taken),
        .ra_val    (ra_val),
        .stall     (stall),
        .NPC       (npc_im),
        .link_addr (link_im),
        .in_slot   (slot_im)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rst, input logic stl, input logic [1:0] op,
                                 input logic tk, input logic [15:0] i16,
                                 input logic [25:0] i26, input logic [31:0] ra);
        reset    = rst;
        stall    = stl;
        npc_op   = op;
        br_taken = tk;
        imm16    = i16;
        imm26    = i26;
        ra_val   = ra;
    endtask

    task automatic computeModel();
        logic [31:0] seq;
        seq          = PC + 32'd4;
        cur_redirect = (npc_op == 2'd2) || (npc_op == 2'd3) || (npc_op == 2'd1 && br_taken);
        case (npc_op)
            2'd1:    cur_tgt = seq + 32'($signed(imm16)) * 32'd4;
            2'd2:    cur_tgt = (seq & 32'hF000_0000) | ({6'd0, imm26} * 32'd4);
            2'd3:    cur_tgt = ra_val;
            default: cur_tgt = seq;
        endcase
        if (reset) begin
            exp_npc     = RST_VEC;
            exp_link    = RST_VEC + 32'd8;
            exp_slot    = 1'b0;
            exp_npc_im  = RST_VEC;
            exp_link_im = RST_VEC + 32'd8;
        end else begin
            exp_slot    = (pend_q.size() != 0);
            exp_link    = PC + 32'd8;
            exp_link_im = PC + 32'd4;
            if (stall)                 exp_npc = PC;
            else if (pend_q.size() != 0) exp_npc = pend_q[0];
            else                       exp_npc = seq;
            if (stall)             exp_npc_im = PC;
            else if (cur_redirect) exp_npc_im = cur_tgt;
            else                   exp_npc_im = seq;
        end
    endtask

    task automatic expectVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic checkOutput(input string tag);
        @(negedge clk);
        computeModel();
        expectVal({tag, ".npc"},      npc_ds,         exp_npc);
        expectVal({tag, ".link"},     link_ds,        exp_link);
        expectVal({tag, ".slot"},     {31'd0, slot_ds}, {31'd0, exp_slot});
        expectVal({tag, ".npc_im"},   npc_im,         exp_npc_im);
        expectVal({tag, ".link_im"},  link_im,        exp_link_im);
        expectVal({tag, ".slot_im"},  {31'd0, slot_im}, 32'd0);
    endtask

    // Clock edge: retire the instruction in the model, then the IFU latches NPC.
    task automatic advance();
        @(posedge clk);
        #1;
        if (reset) begin
            pend_q.delete();
        end else if (!stall) begin
            if (pend_q.size() != 0) void'(pend_q.pop_front());
            else if (cur_redirect)  pend_q.push_back(cur_tgt);
        end
        PC = exp_npc;
    endtask

    task automatic step(input string tag, input logic rst, input logic stl, input logic [1:0] op,
                        input logic tk, input logic [15:0] i16, input logic [25:0] i26,
                        input logic [31:0] ra);
        applyStimulus(rst, stl, op, tk, i16, i26, ra);
        checkOutput(tag);
        advance();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        PC     = 32'd0;
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] sequential run");
        step("rst0", 1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
        checkOutput("rst1");
        expectVal("rst1.vec", npc_ds, 32'h3000);
        expectVal("rst1.link", link_ds, 32'h3008);
        advance();
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
        checkOutput("seq0");
        expectVal("seq0.abs", npc_ds, 32'h3004);
        advance();
        checkOutput("seq1");
        expectVal("seq1.abs", npc_ds, 32'h3008);
        advance();
        checkOutput("seq2");
        expectVal("seq2.abs", npc_ds, 32'h300C);
        advance();
        step("seq3", 1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);

        $display("[TB] taken backward branch");
        expectVal("br.pc", PC, 32'h3010);
        applyStimulus(1'b0, 1'b0, 2'd1, 1'b1, 16'hFFFC, 26'd0, 32'd0);
        checkOutput("br0");
        expectVal("br0.abs", npc_ds, 32'h3014);
        expectVal("br0.im", npc_im, 32'h3004);
        advance();
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
        checkOutput("br1");
        expectVal("br1.slot", {31'd0, slot_ds}, 32'd1);
        expectVal("br1.abs", npc_ds, 32'h3004);
        advance();

        $display("[TB] jal and jr");
        PC = 32'h3020;
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 16'd0, 26'h0000C10, 32'd0);
        checkOutput("jal0");
        expectVal("jal0.link", link_ds, 32'h3028);
        expectVal("jal0.abs", npc_ds, 32'h3024);
        advance();
        step("jal1", 1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
        expectVal("jal.dest", PC, 32'h3040);
        step("jr0", 1'b0, 1'b0, 2'd3, 1'b0, 16'd0, 26'd0, 32'h3028);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
        checkOutput("jr1");
        expectVal("jr1.abs", npc_ds, 32'h3028);
        advance();

        $display("[TB] stall in slot");
        step("stb0", 1'b0, 1'b0, 2'd1, 1'b1, 16'h0010, 26'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
            checkOutput($sformatf("stall%0d", k));
            expectVal($sformatf("stall%0d.hold", k), npc_ds, 32'h302C);
            expectVal($sformatf("stall%0d.slot", k), {31'd0, slot_ds}, 32'd1);
            advance();
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
        checkOutput("stall.rel");
        expectVal("stall.rel.abs", npc_ds, 32'h306C);
        advance();

        $display("[TB] jump in delay slot");
        step("bs0", 1'b0, 1'b0, 2'd1, 1'b1, 16'h0008, 26'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 16'd0, 26'h0001000, 32'd0);
        checkOutput("bs1");
        expectVal("bs1.abs", npc_ds, 32'h3090);
        advance();
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
        checkOutput("bs2");
        expectVal("bs2.slot", {31'd0, slot_ds}, 32'd0);
        expectVal("bs2.abs", npc_ds, 32'h3094);
        advance();

        $display("[TB] reset mid-slot and immediate build");
        step("rs0", 1'b0, 1'b0, 2'd2, 1'b0, 16'd0, 26'h0000500, 32'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
        checkOutput("rs1");
        expectVal("rs1.abs", npc_ds, 32'h3000);
        advance();
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
        checkOutput("rs2");
        expectVal("rs2.abs", npc_ds, 32'h3004);
        expectVal("rs2.slot", {31'd0, slot_ds}, 32'd0);
        advance();
        PC = 32'h3010;
        applyStimulus(1'b0, 1'b0, 2'd1, 1'b1, 16'h0002, 26'd0, 32'd0);
        checkOutput("im0");
        expectVal("im0.abs", npc_im, 32'h301C);
        advance();

        $display("[TB] randomized run");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) PC = $urandom;
            step($sformatf("rand%0d", i),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 16'($urandom),
                 26'($urandom),
                 32'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/npc_sequencer.md
Name: npc_sequencer

Overview:
- Produces the NPC that the IFU latches into PC on each clk edge; it is the driving end of the IFU's NPC/PC interface.
- Consumes the IFU's PC, imm16 and imm26, a decoded npc_op from control, the branch-compare result, the jr source register value and a stall request.
- Implements sequential fetch, beq-style branches, j/jal and jr/jalr.
- Holds a pending-target register so MIPS delay-slot semantics are honoured when enabled.

Parameters:
- RESET_PC, 32'h0000_3000, NPC driven during reset (the IFU reset vector).
- DELAY_SLOT, 1, 1 = taken redirects apply after one delay-slot instruction; 0 = redirect applies immediately.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- PC  in  32  current PC from IFU.
- imm16  in  16  branch offset field from IFU.
- imm26  in  26  jump index field from IFU.
- npc_op  in  2  0 = SEQ, 1 = BRANCH, 2 = JUMP (j/jal), 3 = JREG (jr/jalr).
- br_taken  in  1  branch condition true; only meaningful when npc_op = BRANCH.
- ra_val  in  32  GPR[rs] value, the jr/jalr target.
- stall  in  1  hold PC; the current instruction is not consumed.
- NPC  out  32  next PC to IFU (combinational from state and inputs).
- link_addr  out  32  return address for jal/jalr writeback.
- in_slot  out  1  current instruction is a delay-slot instruction.

Behaviour:
- One clock domain; reset is synchronous and active-high; ports named clk and reset.
- Target arithmetic, all 32-bit with modulo 2^32 wrap:
  - pc4 = PC + 4.
  - br_tgt = pc4 + {{14{imm16[15]}}, imm16, 2'b00}.
  - j_tgt = {pc4[31:28], imm26, 2'b00}.
  - jr_tgt = ra_val, used unmodified; no alignment check or correction.
- redirect = (npc_op == BRANCH && br_taken) || npc_op == JUMP || npc_op == JREG. tgt is the matching target.
- State register st ∈ {S_SEQ, S_SLOT} plus a 32-bit pend_tgt register.
- Reset:
  - st <= S_SEQ, pend_tgt <= 0.
  - While reset = 1, NPC = RESET_PC, in_slot = 0, link_addr = RESET_PC + 8.
- DELAY_SLOT = 1:
  - S_SEQ, stall = 1: NPC = PC; state unchanged.
  - S_SEQ, stall = 0, redirect: NPC = pc4; at clk, pend_tgt <= tgt and st <= S_SLOT.
  - S_SEQ, stall = 0, no redirect: NPC = pc4.
  - S_SLOT, stall = 0: NPC = pend_tgt; st <= S_SEQ. Any redirect decoded in the slot is ignored (a branch in a delay slot is defined as ignored).
  - S_SLOT, stall = 1: NPC = PC; remain S_SLOT; pend_tgt held.
  - in_slot = (st == S_SLOT).
  - link_addr = PC + 8.
- DELAY_SLOT = 0:
  - st stays S_SEQ.
  - NPC = stall ? PC : (redirect ? tgt : pc4).
  - link_addr = PC + 4; in_slot = 0.
- Simultaneous events:
  - reset overrides stall and redirect.
  - stall overrides redirect; the redirect is re-evaluated on the cycle the stall releases.
- Reset mid-slot: pending target discarded; the first NPC after reset deasserts is RESET_PC + 4.
- Not-taken branch (BRANCH with br_taken = 0) behaves as SEQ with no state change.
- Latency: NPC is combinational, so a redirect reaches the IFU PC at the next edge (DELAY_SLOT = 0) or the edge after (DELAY_SLOT = 1).

Decomposition:
- Shared package (cpu_defs):
  - NPC_SEQ/NPC_BRANCH/NPC_JUMP/NPC_JREG localparams.
  - S_SEQ/S_SLOT encodings.
  - RESET_PC default.
- One natural sub-module, npc_target_calc: combinational pc4/br_tgt/j_tgt/jr_tgt and the target mux.
- npc_sequencer keeps the FSM, pend_tgt, and the stall/reset muxing.

Test Plan:
1. Sequential run:
   - reset for 2 cycles, then release with npc_op = SEQ, PC fed back from NPC via an IFU model.
   - NPC = 0x3000 during reset, then 0x3004, 0x3008, 0x300C on successive cycles.
2. Taken backward branch, DELAY_SLOT = 1:
   - PC = 0x3010, npc_op = BRANCH, br_taken = 1, imm16 = 16'hFFFC.
   - NPC = 0x3014 with in_slot = 1 next cycle.
   - The cycle after, NPC = 0x3004.
3. jal/jr:
   - PC = 0x3020, JUMP, imm26 = 26'h0000C10: link_addr = 0x3028, NPC = 0x3024, then 0x3040.
   - Later, JREG with ra_val = 0x3028: NPC = 0x3028 after the slot.
4. Stall interplay:
   - Stall asserted in S_SLOT for 3 cycles: NPC = PC each cycle, in_slot stays 1.
   - On release, NPC = pend_tgt.
5. Branch in the slot:
   - Slot instruction presents JUMP to 0x4000.
   - Ignored; NPC = the first target; state returns to S_SEQ.
6. Edge cases:
   - Reset asserted during S_SLOT: next cycle NPC = 0x3000, in_slot = 0.
   - DELAY_SLOT = 0 build with taken BRANCH at 0x3010, imm16 = 2: NPC = 0x301C immediately.
